// File: rtl/grid_access_sched.sv
// grid_access_sched
//   Arbitrates a single-port trail RAM between VGA reads and a game engine
//   that clears the grid and runs per-step collision check / trail marking.
//
//   Parameter:
//     GRID_BITS  bits per grid coordinate (grid is 2^GRID_BITS square)
//   Optional feature:
//     GRID_BORDER_EN  when defined, CLEAR paints the outer ring of cells 2'b11
//   Ports:
//     DIV_CLK, reset          clock (rising edge), synchronous active-high reset
//     clear_req, step_req     level requests, accepted only in IDLE
//     p1_x/p1_y/p2_x/p2_y     player heads, latched when a step is accepted
//     vga_req, vga_x, vga_y   VGA read request; always granted the RAM port
//     vga_valid, vga_rdata    read-data strobe one cycle after a VGA grant
//     mem_addr/we/wdata       RAM port ({y,x} address), mem_rdata is 1-cycle latency
//     step_done, clear_done   one-cycle completion pulses
//     p1_hit, p2_hit          collision results, held between steps
//     busy                    engine not in IDLE
//     dbg_state               current engine state encoding
//
//   Handshake: a request is a level; it is consumed on the rising edge where
//   the engine is IDLE and VGA is not granted. There is no backpressure on
//   vga_req: a VGA cycle always wins the RAM and freezes the engine for that
//   cycle, and vga_valid answers it exactly one cycle later.
module grid_access_sched #(
  parameter int GRID_BITS = 6
) (
  input  logic                   DIV_CLK,
  input  logic                   reset,
  input  logic                   clear_req,
  input  logic                   step_req,
  input  logic [GRID_BITS-1:0]   p1_x,
  input  logic [GRID_BITS-1:0]   p1_y,
  input  logic [GRID_BITS-1:0]   p2_x,
  input  logic [GRID_BITS-1:0]   p2_y,
  input  logic                   vga_req,
  input  logic [GRID_BITS-1:0]   vga_x,
  input  logic [GRID_BITS-1:0]   vga_y,
  output logic                   vga_valid,
  output logic [1:0]             vga_rdata,
  output logic [2*GRID_BITS-1:0] mem_addr,
  output logic                   mem_we,
  output logic [1:0]             mem_wdata,
  input  logic [1:0]             mem_rdata,
  output logic                   step_done,
  output logic                   clear_done,
  output logic                   p1_hit,
  output logic                   p2_hit,
  output logic                   busy,
  output logic [2:0]             dbg_state
);

  localparam int AW = 2 * GRID_BITS;
  localparam logic [AW-1:0]        LAST_ADDR = '1;
  localparam logic [GRID_BITS-1:0] CMAX      = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RD1   = 3'd2,
    RD2   = 3'd3,
    WAIT  = 3'd4,
    WR1   = 3'd5,
    WR2   = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t          state, state_next;
  logic [AW-1:0]   sweep;
  logic [AW-1:0]   addr1, addr2;
  logic            same_cell;
  logic            is_clear;
  logic            iss1, iss2;       // own read issued last cycle
  logic [1:0]      cell1, cell2;
  logic [1:0]      clear_val;
  logic            grant;

  // Reset gates the grant so the RAM port idles at 0 while in reset.
  assign grant     = vga_req & ~reset;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign vga_rdata = vga_valid ? mem_rdata : 2'b00;

`ifdef GRID_BORDER_EN
  logic [GRID_BITS-1:0] sx, sy;
  assign sx = sweep[GRID_BITS-1:0];
  assign sy = sweep[AW-1:GRID_BITS];
  assign clear_val = ((sx == '0) || (sx == CMAX) || (sy == '0) || (sy == CMAX)) ? 2'b11 : 2'b00;
`else
  assign clear_val = 2'b00;
`endif

  always_comb begin
    state_next = state;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = 2'b00;
    step_done  = 1'b0;
    clear_done = 1'b0;
    if (grant) begin
      mem_addr = {vga_y, vga_x};
    end else begin
      case (state)
        IDLE: begin
          if (clear_req)     state_next = CLEAR;
          else if (step_req) state_next = RD1;
        end
        CLEAR: begin
          mem_addr  = sweep;
          mem_we    = 1'b1;
          mem_wdata = clear_val;
          if (sweep == LAST_ADDR) state_next = DONE;
        end
        RD1: begin
          mem_addr   = addr1;
          state_next = RD2;
        end
        RD2: begin
          mem_addr   = addr2;
          state_next = WAIT;
        end
        WAIT: state_next = WR1;
        WR1: begin
          mem_addr   = addr1;
          mem_we     = 1'b1;
          mem_wdata  = same_cell ? 2'b11 : (cell1 | 2'b01);
          state_next = same_cell ? DONE : WR2;
        end
        WR2: begin
          mem_addr   = addr2;
          mem_we     = 1'b1;
          mem_wdata  = cell2 | 2'b10;
          state_next = DONE;
        end
        DONE: begin
          // Pulse only on the cycle DONE actually retires, so a VGA stall
          // here cannot stretch the pulse.
          if (is_clear) clear_done = 1'b1;
          else          step_done  = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge DIV_CLK) begin
    if (reset) begin
      state     <= IDLE;
      sweep     <= '0;
      addr1     <= '0;
      addr2     <= '0;
      same_cell <= 1'b0;
      is_clear  <= 1'b0;
      iss1      <= 1'b0;
      iss2      <= 1'b0;
      cell1     <= 2'b00;
      cell2     <= 2'b00;
      p1_hit    <= 1'b0;
      p2_hit    <= 1'b0;
      vga_valid <= 1'b0;
    end else begin
      vga_valid <= grant;
      iss1      <= (state == RD1) && !grant;
      iss2      <= (state == RD2) && !grant;
      // Capture keys off the engine's own read, so a VGA read that lands on
      // the data bus in a later stalled cycle is never mistaken for it.
      if (iss1) begin
        cell1  <= mem_rdata;
        p1_hit <= (|mem_rdata) | same_cell;
      end
      if (iss2) begin
        cell2  <= mem_rdata;
        p2_hit <= (|mem_rdata) | same_cell;
      end
      state <= state_next;
      if (!grant) begin
        if (state == IDLE && state_next == CLEAR) begin
          sweep    <= '0;
          is_clear <= 1'b1;
        end
        if (state == IDLE && state_next == RD1) begin
          addr1     <= {p1_y, p1_x};
          addr2     <= {p2_y, p2_x};
          same_cell <= ({p1_y, p1_x} == {p2_y, p2_x});
          is_clear  <= 1'b0;
        end
        // Holds at the last address rather than wrapping.
        if (state == CLEAR && sweep != LAST_ADDR) sweep <= sweep + AW'(1);
      end
    end
  end

endmodule
